mem_bus_arbiter: RTL and testbench

Two-port memory bus controller that shares the unified register/RAM address space between the instruction-fetch path and the load/store (data) path. It arbitrates round-robin between the two requesters and drives one access at a time onto the address bus feeding the address selector. It also sequences single-cycle register accesses and multi-cycle RAM accesses, returning read data and a one-cycle acknowledge to the winning requester.

---
 rtl/mem_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the register/RAM bus between the fetch and data ports.
// Register accesses occupy the bus for one cycle; RAM accesses for RAM_LAT cycles.
module mem_bus_arbiter #(
  parameter int unsigned RAM_LAT = 2,
  parameter int unsigned REG_TOP = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [15:0] D_ADD,
  input  logic [15:0] D_WDATA,
  output logic        D_ACK,
  output logic [15:0] D_RDATA,
  input  logic        I_REQ,
  input  logic [15:0] I_ADD,
  output logic        I_ACK,
  output logic [15:0] I_RDATA,
  output logic [15:0] ADD,
  output logic [15:0] WDATA,
  output logic        WE,
  output logic        RE,
  input  logic [15:0] RDATA,
  output logic        BUSY
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam logic [AW-1:0] REG_TOP_ADD = AW'(REG_TOP);
  localparam logic [CW-1:0] RAM_WAIT    = CW'(RAM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            port_fetch_q, port_fetch_d;
  logic            last_fetch_q, last_fetch_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   add_q, add_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            re_q, re_d;
  logic            d_ack_q, d_ack_d;
  logic            i_ack_q, i_ack_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic            busy_q, busy_d;

  logic            gnt_any;
  logic            gnt_fetch;
  logic [AW-1:0]   gnt_add;

  // Fetch wins only when data is idle or data was served last.
  assign gnt_any   = D_REQ | I_REQ;
  assign gnt_fetch = I_REQ & (~D_REQ | ~last_fetch_q);
  assign gnt_add   = gnt_fetch ? I_ADD : D_ADD;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      port_fetch_q <= 1'b0;
      last_fetch_q <= 1'b1;
      wr_q         <= 1'b0;
      add_q        <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      d_ack_q      <= 1'b0;
      i_ack_q      <= 1'b0;
      d_rdata_q    <= '0;
      i_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      port_fetch_q <= port_fetch_d;
      last_fetch_q <= last_fetch_d;
      wr_q         <= wr_d;
      add_q        <= add_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      re_q         <= re_d;
      d_ack_q      <= d_ack_d;
      i_ack_q      <= i_ack_d;
      d_rdata_q    <= d_rdata_d;
      i_rdata_q    <= i_rdata_d;
      busy_q       <= busy_d;
    end
  end

  // Next state and wait counter; counter preloads with the access length minus one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = ACCESS;
          cnt_d   = (gnt_add <= REG_TOP_ADD) ? '0 : RAM_WAIT;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered bus, acknowledge and read-data outputs.
  always_comb begin
    port_fetch_d = port_fetch_q;
    last_fetch_d = last_fetch_q;
    wr_d         = wr_q;
    add_d        = add_q;
    wdata_d      = wdata_q;
    d_rdata_d    = d_rdata_q;
    i_rdata_d    = i_rdata_q;
    we_d         = 1'b0;
    re_d         = 1'b0;
    d_ack_d      = 1'b0;
    i_ack_d      = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          port_fetch_d = gnt_fetch;
          add_d        = gnt_add;
          wdata_d      = gnt_fetch ? '0 : D_WDATA;
          wr_d         = ~gnt_fetch & D_WE;
          we_d         = ~gnt_fetch & D_WE;
          re_d         = ~(~gnt_fetch & D_WE);
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          we_d = wr_q;
          re_d = ~wr_q;
        end else begin
          if (!wr_q) begin
            if (port_fetch_q) i_rdata_d = RDATA;
            else              d_rdata_d = RDATA;
          end
          last_fetch_d = port_fetch_q;
          d_ack_d      = ~port_fetch_q;
          i_ack_d      = port_fetch_q;
        end
      end
      default: ;
    endcase
  end

  assign ADD     = add_q;
  assign WDATA   = wdata_q;
  assign WE      = we_q;
  assign RE      = re_q;
  assign D_ACK   = d_ack_q;
  assign I_ACK   = i_ack_q;
  assign D_RDATA = d_rdata_q;
  assign I_RDATA = i_rdata_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (RAM_LAT=3, REG_TOP=16) with a simple XOR memory model.
module tb_mem_bus_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        D_REQ, D_WE;
  logic [15:0] D_ADD, D_WDATA;
  logic        D_ACK;
  logic [15:0] D_RDATA;
  logic        I_REQ;
  logic [15:0] I_ADD;
  logic        I_ACK;
  logic [15:0] I_RDATA;
  logic [15:0] ADD, WDATA;
  logic        WE, RE;
  logic [15:0] RDATA;
  logic        BUSY;

  logic        use_force;
  logic [15:0] rdata_force;

  int checks   = 0;
  int failures = 0;
  int re_cnt   = 0;
  int we_cnt   = 0;
  int dack_cnt = 0;

  mem_bus_arbiter #(.RAM_LAT(3), .REG_TOP(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADD(D_ADD), .D_WDATA(D_WDATA),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA),
    .I_REQ(I_REQ), .I_ADD(I_ADD), .I_ACK(I_ACK), .I_RDATA(I_RDATA),
    .ADD(ADD), .WDATA(WDATA), .WE(WE), .RE(RE), .RDATA(RDATA), .BUSY(BUSY)
  );

  assign RDATA = use_force ? rdata_force : (ADD ^ 16'hA5A5);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RE === 1'b1)    re_cnt   <= re_cnt + 1;
    if (WE === 1'b1)    we_cnt   <= we_cnt + 1;
    if (D_ACK === 1'b1) dack_cnt <= dack_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (BUSY !== 1'b1 && n < 20);
  endtask

  task automatic wait_ack(input bit fetch, output int lat);
    lat = 0;
    while (lat < 40) begin
      tick(1);
      lat++;
      if ((fetch ? I_ACK : D_ACK) === 1'b1) break;
    end
  endtask

  int n, lat, re0, we0, dack0;
  bit exp_fetch;

  initial begin
    RST_N = 1'b0; D_REQ = 1'b1; I_REQ = 1'b1; D_WE = 1'b0;
    D_ADD = 16'h0003; D_WDATA = 16'h0000; I_ADD = 16'h0004;
    use_force = 1'b0; rdata_force = 16'h0000;

    // Reset held with both requests pending
    tick(3);
    check("rst_add", 32'(ADD), 32'h0);
    check("rst_wdata", 32'(WDATA), 32'h0);
    check("rst_we", 32'(WE), 32'h0);
    check("rst_re", 32'(RE), 32'h0);
    check("rst_dack", 32'(D_ACK), 32'h0);
    check("rst_iack", 32'(I_ACK), 32'h0);
    check("rst_drdata", 32'(D_RDATA), 32'h0);
    check("rst_irdata", 32'(I_RDATA), 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);

    @(negedge CLK);
    RST_N = 1'b1;
    wait_grant(n);
    check("first_grant_lat", 32'(n), 32'd1);
    check("first_grant_data_add", 32'(ADD), 32'h0003);
    check("first_grant_re", 32'(RE), 32'h1);
    check("first_grant_we", 32'(WE), 32'h0);
    wait_ack(1'b0, lat);
    check("first_dack_lat", 32'(lat), 32'd1);
    check("first_drdata", 32'(D_RDATA), 32'h0000A5A6);
    check("first_no_iack", 32'(I_ACK), 32'h0);
    D_REQ = 1'b0;
    wait_grant(n);
    check("second_grant_lat", 32'(n), 32'd2);
    check("second_grant_fetch_add", 32'(ADD), 32'h0004);
    wait_ack(1'b1, lat);
    check("second_iack_lat", 32'(lat), 32'd1);
    check("second_irdata", 32'(I_RDATA), 32'h0000A5A1);
    I_REQ = 1'b0;
    tick(1);
    check("second_idle", 32'(BUSY), 32'h0);

    // Register write
    D_REQ = 1'b1; D_WE = 1'b1; D_ADD = 16'h0005; D_WDATA = 16'hBEEF;
    we0 = we_cnt;
    wait_grant(n);
    check("wr_grant_lat", 32'(n), 32'd1);
    check("wr_add", 32'(ADD), 32'h0005);
    check("wr_wdata", 32'(WDATA), 32'h0000BEEF);
    check("wr_we", 32'(WE), 32'h1);
    check("wr_re", 32'(RE), 32'h0);
    wait_ack(1'b0, lat);
    check("wr_ack_lat", 32'(lat), 32'd1);
    check("wr_we_cycles", 32'(we_cnt - we0), 32'd1);
    check("wr_we_low_resp", 32'(WE), 32'h0);
    check("wr_drdata_kept", 32'(D_RDATA), 32'h0000A5A6);
    D_REQ = 1'b0; D_WE = 1'b0;
    tick(1);
    check("wr_dack_one_cycle", 32'(D_ACK), 32'h0);
    check("wr_idle", 32'(BUSY), 32'h0);

    // Fetch reads at the region boundaries
    use_force = 1'b1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin I_ADD = 16'h0011; rdata_force = 16'h1234; end
        1: begin I_ADD = 16'h0010; rdata_force = 16'h0BAD; end
        default: begin I_ADD = 16'hFFFF; rdata_force = 16'h7777; end
      endcase
      I_REQ = 1'b1;
      re0 = re_cnt;
      wait_grant(n);
      check("rd_grant_add", 32'(ADD), 32'(I_ADD));
      wait_ack(1'b1, lat);
      check("rd_ack_lat", 32'(lat), (k == 1) ? 32'd1 : 32'd3);
      check("rd_re_cycles", 32'(re_cnt - re0), (k == 1) ? 32'd1 : 32'd3);
      check("rd_irdata", 32'(I_RDATA), 32'(rdata_force));
      check("rd_re_low_resp", 32'(RE), 32'h0);
      I_REQ = 1'b0;
      tick(1);
      check("rd_idle", 32'(BUSY), 32'h0);
    end
    use_force = 1'b0;

    // Both ports hammering register reads: strict alternation, data first
    D_ADD = 16'h0001; I_ADD = 16'h0002; D_WE = 1'b0;
    D_REQ = 1'b1; I_REQ = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        tick(1);
        n++;
      end while (D_ACK !== 1'b1 && I_ACK !== 1'b1 && n < 10);
      exp_fetch = (k % 2) == 1;
      check("alt_spacing", 32'(n), (k == 0) ? 32'd2 : 32'd3);
      check("alt_dack", 32'(D_ACK), 32'(!exp_fetch));
      check("alt_iack", 32'(I_ACK), 32'(exp_fetch));
      if (exp_fetch) check("alt_irdata", 32'(I_RDATA), 32'h0000A5A7);
      else           check("alt_drdata", 32'(D_RDATA), 32'h0000A5A4);
    end
    D_REQ = 1'b0; I_REQ = 1'b0;
    tick(1);
    check("alt_idle", 32'(BUSY), 32'h0);

    // Reset during the second cycle of a RAM write, then reissue
    D_REQ = 1'b1; D_WE = 1'b1; D_ADD = 16'h0100; D_WDATA = 16'h5555;
    dack0 = dack_cnt;
    wait_grant(n);
    tick(1);
    check("abort_we_before", 32'(WE), 32'h1);
    #2 RST_N = 1'b0;
    #1;
    check("abort_we_drop", 32'(WE), 32'h0);
    check("abort_busy", 32'(BUSY), 32'h0);
    check("abort_add", 32'(ADD), 32'h0);
    repeat (2) @(negedge CLK);
    check("abort_no_dack", 32'(D_ACK), 32'h0);
    RST_N = 1'b1;
    we0 = we_cnt;
    wait_grant(n);
    check("reissue_grant_lat", 32'(n), 32'd1);
    check("reissue_add", 32'(ADD), 32'h0100);
    wait_ack(1'b0, lat);
    check("reissue_lat", 32'(lat), 32'd3);
    check("reissue_we_cycles", 32'(we_cnt - we0), 32'd3);
    D_REQ = 1'b0; D_WE = 1'b0;
    tick(1);
    check("reissue_one_dack", 32'(dack_cnt - dack0), 32'd1);

    // Data request arriving during a fetch ACK wins the next grant
    I_ADD = 16'h0003; I_REQ = 1'b1;
    wait_grant(n);
    wait_ack(1'b1, lat);
    check("rr_fetch_lat", 32'(lat), 32'd1);
    D_ADD = 16'h0007; D_REQ = 1'b1;
    wait_grant(n);
    check("rr_data_grant_lat", 32'(n), 32'd2);
    check("rr_data_first", 32'(ADD), 32'h0007);
    wait_ack(1'b0, lat);
    check("rr_data_lat", 32'(lat), 32'd1);
    check("rr_drdata", 32'(D_RDATA), 32'h0000A5A2);
    D_REQ = 1'b0;
    wait_grant(n);
    check("rr_fetch_second", 32'(ADD), 32'h0003);
    wait_ack(1'b1, lat);
    check("rr_fetch2_lat", 32'(lat), 32'd1);
    check("rr_irdata", 32'(I_RDATA), 32'h0000A5A6);
    I_REQ = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
